// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch and an
// IF/ID output register with a one-entry skid buffer and redirect flush.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Resetb,
  output logic        ImemReq,
  output logic [63:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output logic [31:0] InstOut,
  output logic [63:0] PCOut,
  output logic        InstValid,
  output logic [63:0] CurrentPC
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] skid_inst_q, skid_inst_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pcout_q, pcout_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic slot_free;
  logic handshake;

  assign slot_free = !valid_q || !Stall;
  assign handshake = (state_q == S_FETCH) && req_q && ImemReady;

  // Next-state and registered-output logic; redirect overrides everything.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    inst_d      = inst_q;
    pcout_d     = pcout_q;
    valid_d     = slot_free ? 1'b0 : valid_q;

    unique case (state_q)
      S_FETCH: begin
        if (handshake) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ImemRspValid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else if (slot_free) begin
            inst_d  = ImemRspData;
            pcout_d = req_pc_q;
            valid_d = 1'b1;
            state_d = S_FETCH;
          end else begin
            skid_inst_d = ImemRspData;
            skid_pc_d   = req_pc_q;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!Stall) begin
          inst_d  = skid_inst_q;
          pcout_d = skid_pc_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    if (Redirect) begin
      pc_d        = RedirectPC & ~XLEN'(3);
      valid_d     = 1'b0;
      skid_inst_d = '0;
      skid_pc_d   = '0;
      // Only a request still in flight after this edge needs its response dropped.
      if (handshake || (state_q == S_WAIT && !ImemRspValid)) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = S_FETCH;
        drop_d  = 1'b0;
      end
    end

    req_d  = (state_d == S_FETCH);
    addr_d = pc_d;
  end

  always_ff @(posedge CLK or negedge Resetb) begin
    if (!Resetb) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      inst_q      <= INST_NOP;
      pcout_q     <= '0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      inst_q      <= inst_d;
      pcout_q     <= pcout_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
    end
  end

  assign ImemReq   = req_q;
  assign ImemAddr  = addr_q;
  assign InstOut   = inst_q;
  assign PCOut     = pcout_q;
  assign InstValid = valid_q;
  assign CurrentPC = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural imem with programmable latency, a table of
// start-up vectors, hand sequences for stall/redirect/wrap/reset, and a scoreboard.
module tb_if_stage;

  logic        CLK = 1'b0;
  logic        Resetb;
  logic        ImemReq;
  logic [63:0] ImemAddr;
  logic        ImemReady;
  logic        ImemRspValid;
  logic [31:0] ImemRspData;
  logic        Stall;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic [31:0] InstOut;
  logic [63:0] PCOut;
  logic        InstValid;
  logic [63:0] CurrentPC;

  if_stage #(.RESET_PC(64'h100), .INST_NOP(32'h0000_0000)) dut (
    .CLK(CLK), .Resetb(Resetb), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .InstOut(InstOut), .PCOut(PCOut), .InstValid(InstValid), .CurrentPC(CurrentPC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pcout;
    logic [63:0] exp_cur;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          pending  = 0;   // 0 none, 1 live request, 2 wrong-path request
  logic [63:0] req_addr = '0;
  int          mem_lat  = 1;
  int          rsp_cnt  = 0;
  logic [63:0] rsp_addr = '0;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: scoreboard/memory bookkeeping before the edge, memory response after it.
  task automatic tick();
    logic        hs;
    logic [63:0] a;
    exp_t        e;
    hs = Resetb && ImemReq && ImemReady;
    a  = ImemAddr;
    if (Resetb && InstValid && !Stall && !Redirect) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got pc %h expected no instruction", PCOut);
      end else begin
        e = sb.pop_front();
        check("sb_pc", PCOut, e.pc);
        check("sb_inst", 64'(InstOut), 64'(e.inst));
      end
    end
    if (Resetb && Redirect) begin
      sb.delete();
      if (hs) pending = 2;
      else if (ImemRspValid) pending = 0;
      else if (pending == 1) pending = 2;
    end else if (Resetb) begin
      if (ImemRspValid && pending != 0) begin
        if (pending == 1) begin
          e.pc   = req_addr;
          e.inst = word(req_addr);
          sb.push_back(e);
        end
        pending = 0;
      end
      if (hs) begin
        pending  = 1;
        req_addr = a;
      end
    end
    @(posedge CLK);
    #1;
    ImemRspValid = 1'b0;
    if (hs) begin
      rsp_cnt  = mem_lat;
      rsp_addr = a;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        ImemRspValid = 1'b1;
        ImemRspData  = word(rsp_addr);
      end
    end
  endtask

  task automatic wait_valid(input string nm, input logic [63:0] exp_pc);
    int n;
    n = 0;
    while (!InstValid && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_valid"}, 64'(InstValid), 64'd1);
    check({nm, "_pcout"}, PCOut, exp_pc);
    check({nm, "_inst"}, 64'(InstOut), 64'(word(exp_pc)));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_req"}, 64'(ImemReq), 64'd0);
    check({nm, "_addr"}, ImemAddr, 64'h0);
    check({nm, "_valid"}, 64'(InstValid), 64'd0);
    check({nm, "_inst"}, 64'(InstOut), 64'h0);
    check({nm, "_pcout"}, PCOut, 64'h0);
    check({nm, "_cur"}, CurrentPC, 64'h100);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{stall: 1'b0, exp_req: 1'b1, exp_addr: 64'h100, exp_valid: 1'b0, exp_pcout: 64'h0,   exp_cur: 64'h100};
    tbl[1] = '{stall: 1'b0, exp_req: 1'b0, exp_addr: 64'h0,   exp_valid: 1'b0, exp_pcout: 64'h0,   exp_cur: 64'h104};
    tbl[2] = '{stall: 1'b0, exp_req: 1'b1, exp_addr: 64'h104, exp_valid: 1'b1, exp_pcout: 64'h100, exp_cur: 64'h104};
    tbl[3] = '{stall: 1'b0, exp_req: 1'b0, exp_addr: 64'h0,   exp_valid: 1'b0, exp_pcout: 64'h0,   exp_cur: 64'h108};
    tbl[4] = '{stall: 1'b0, exp_req: 1'b1, exp_addr: 64'h108, exp_valid: 1'b1, exp_pcout: 64'h104, exp_cur: 64'h108};

    Resetb       = 1'b0;
    ImemReady    = 1'b1;
    ImemRspValid = 1'b0;
    ImemRspData  = '0;
    Stall        = 1'b0;
    Redirect     = 1'b0;
    RedirectPC   = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("rst");
    @(negedge CLK);
    Resetb = 1'b1;

    // Zero-wait start-up: first valid on the third edge, then one per two cycles.
    for (int i = 0; i < 5; i++) begin
      Stall = tbl[i].stall;
      tick();
      check($sformatf("tbl%0d_req", i), 64'(ImemReq), 64'(tbl[i].exp_req));
      if (tbl[i].exp_req) check($sformatf("tbl%0d_addr", i), ImemAddr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), 64'(InstValid), 64'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_cur", i), CurrentPC, tbl[i].exp_cur);
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_pcout", i), PCOut, tbl[i].exp_pcout);
        check($sformatf("tbl%0d_inst", i), 64'(InstOut), 64'(word(tbl[i].exp_pcout)));
      end
    end

    // Stall for 5 cycles while 0x104 is presented; 0x108 lands in the skid.
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_pcout", i), PCOut, 64'h104);
      check($sformatf("stall%0d_valid", i), 64'(InstValid), 64'd1);
      check($sformatf("stall%0d_req", i), 64'(ImemReq), 64'd0);
    end
    Stall = 1'b0;
    tick();
    check("unstall_valid", 64'(InstValid), 64'd1);
    check("unstall_pcout", PCOut, 64'h108);
    check("unstall_req", 64'(ImemReq), 64'd1);
    check("unstall_addr", ImemAddr, 64'h10C);

    // Redirect while the 0x10C request is outstanding.
    mem_lat = 3;
    tick();
    Redirect   = 1'b1;
    RedirectPC = 64'h2003;
    tick();
    Redirect = 1'b0;
    check("redir_valid", 64'(InstValid), 64'd0);
    check("redir_cur", CurrentPC, 64'h2000);
    tick();
    tick();
    check("redir_req", 64'(ImemReq), 64'd1);
    check("redir_addr", ImemAddr, 64'h2000);
    check("redir_valid2", 64'(InstValid), 64'd0);
    mem_lat = 1;
    wait_valid("redir_first", 64'h2000);

    // Redirect on the same edge as a handshake, with Stall high.
    check("rhs_pre_req", 64'(ImemReq), 64'd1);
    Redirect   = 1'b1;
    RedirectPC = 64'h3000;
    Stall      = 1'b1;
    tick();
    Redirect = 1'b0;
    Stall    = 1'b0;
    check("rhs_valid", 64'(InstValid), 64'd0);
    check("rhs_req", 64'(ImemReq), 64'd0);
    tick();
    check("rhs_req2", 64'(ImemReq), 64'd1);
    check("rhs_addr", ImemAddr, 64'h3000);
    check("rhs_valid2", 64'(InstValid), 64'd0);
    wait_valid("rhs_first", 64'h3000);

    // PC wrap from the top of the address space.
    ImemReady  = 1'b0;
    Redirect   = 1'b1;
    RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    Redirect = 1'b0;
    check("wrap_addr", ImemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_req", 64'(ImemReq), 64'd1);
    ImemReady = 1'b1;
    tick();
    check("wrap_cur", CurrentPC, 64'h0);
    wait_valid("wrap_first", 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next_addr", ImemAddr, 64'h0);

    // Asynchronous reset in the middle of WAIT, then a stale response.
    mem_lat = 4;
    tick();
    check("midwait_req", 64'(ImemReq), 64'd0);
    tick();
    #2;
    Resetb = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    rsp_cnt      = 0;
    pending      = 0;
    sb.delete();
    ImemRspValid = 1'b0;
    mem_lat      = 1;
    @(negedge CLK);
    Resetb       = 1'b1;
    ImemReady    = 1'b0;
    ImemRspValid = 1'b1;
    ImemRspData  = 32'hBAD0_0000;
    tick();
    ImemRspValid = 1'b1;
    check("stale_req", 64'(ImemReq), 64'd1);
    check("stale_addr", ImemAddr, 64'h100);
    check("stale_valid", 64'(InstValid), 64'd0);
    tick();
    check("stale_valid2", 64'(InstValid), 64'd0);
    check("stale_cur", CurrentPC, 64'h100);
    ImemRspValid = 1'b0;
    ImemReady    = 1'b1;
    wait_valid("post_rst", 64'h100);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage with IF/ID output register; feeds the decode-stage sign extender and control decoder.
- Holds the PC, issues one-outstanding-request fetches to instruction memory over a req/ready + response-valid handshake.
- Presents Inst/PC pairs to decode with valid/stall flow control.
- Accepts branch/flush redirects from execute, discarding any in-flight or buffered wrong-path instruction.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- INST_NOP, 32'h0000_0000, value driven on InstOut at reset (decodes to a zero immediate).

Ports:
- CLK  in  1  clock, rising edge
- Resetb  in  1  asynchronous active-low reset
- ImemReq  out  1  fetch request valid
- ImemAddr  out  64  fetch address (PC), bits [1:0] always 0
- ImemReady  in  1  memory accepts request this cycle
- ImemRspValid  in  1  response data valid
- ImemRspData  in  32  fetched instruction word
- Stall  in  1  decode cannot accept InstOut this cycle
- Redirect  in  1  flush and load RedirectPC
- RedirectPC  in  64  new fetch address; bits [1:0] ignored, forced 0
- InstOut  out  32  IF/ID instruction
- PCOut  out  64  address of InstOut
- InstValid  out  1  InstOut/PCOut valid
- CurrentPC  out  64  next address to request

Behaviour:
- Reset (Resetb=0, asynchronous):
  - PC=RESET_PC, state=FETCH, Drop=0, skid empty.
  - InstValid=0, InstOut=INST_NOP, PCOut=0, ImemReq=0, ImemAddr=0.
  - After Resetb deasserts, ImemReq rises on the first CLK edge.
  - Reset mid-operation abandons any outstanding request. A response arriving after reset release while in FETCH is ignored.
- Outputs are registered. ImemAddr equals PC in FETCH. CurrentPC equals PC.
- Output slot is free when InstValid=0 or Stall=0. Decode consumes InstOut on every cycle where InstValid=1 and Stall=0.
- If the slot is free and no new instruction is loaded, InstValid falls to 0 next cycle.
- FETCH:
  - ImemReq=1, ImemAddr=PC.
  - On ImemReq&ImemReady: latch ReqPC=PC, PC<=PC+4 (64-bit modulo, wraps to 0), go to WAIT, ImemReq=0.
  - ImemRspValid in FETCH is ignored.
- WAIT:
  - On ImemRspValid with Drop=1: discard the data, clear Drop, go to FETCH.
  - On ImemRspValid with Drop=0 and slot free: InstOut<=ImemRspData, PCOut<=ReqPC, InstValid<=1, go to FETCH. Response to InstValid latency is 1 cycle.
  - On ImemRspValid with Drop=0 and slot not free: capture the data and ReqPC into the skid register, go to HOLD.
- HOLD:
  - ImemReq=0.
  - When Stall=0: move the skid register to the output, InstValid=1, go to FETCH.
  - While Stall stays high, the output and skid are held unchanged.
- Redirect (highest priority, any state, overrides Stall):
  - PC<=RedirectPC&~3, InstValid<=0, skid cleared.
  - FETCH without handshake that cycle: stay in FETCH; next request uses the new PC.
  - FETCH with ImemReq&ImemReady the same cycle: go to WAIT with Drop=1 (the old-PC request is in flight).
  - WAIT with no response: stay in WAIT, Drop=1.
  - WAIT with a response the same cycle: discard it, go to FETCH.
  - HOLD: go to FETCH.
- Throughput: at most one request outstanding; peak rate is one instruction per 2 cycles with a zero-wait memory.
- No output changes on a cycle with no handshake, response, stall release, or redirect.

Test Plan:
- Reset with RESET_PC=64'h100; zero-wait memory returns address-tagged words → PCOut sequence 0x100, 0x104, 0x108; InstOut matches; InstValid pulses; first InstValid within 3 cycles of Resetb release.
- Stall=1 for 5 cycles while holding 0x104, next response arrives → InstOut/PCOut held at 0x104, state HOLD, ImemReq=0; Stall drop → 0x108 presented next cycle, no instruction lost or duplicated.
- Redirect to 64'h2003 while a request for 0x10C is outstanding → response for 0x10C discarded; next ImemAddr=0x2000; next InstValid carries PCOut=0x2000.
- Redirect coinciding with ImemReq&ImemReady and with Stall=1 → InstValid=0 next cycle; the old response is dropped; fetch resumes at RedirectPC.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetch → next ImemAddr=0; Resetb pulsed low mid-WAIT → all outputs at reset values asynchronously; a stale ImemRspValid after release is ignored.
